// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared size/state encodings for the data memory arbiter
package datamem_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Reserved size or an address not aligned to the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with optional fixed priority
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  input  logic       i_fixed_prio,
  output logic [1:0] o_gnt
);

  logic r_last_grant;

  always_comb begin
    o_gnt = 2'b00;
    if (i_grant_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (i_fixed_prio || r_last_grant) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Starts at 1 so port 0 wins the first tie after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (|o_gnt) begin
      r_last_grant <= o_gnt[1];
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - shares a big-endian word memory between two requesters
// with byte/half/word access and read-modify-write for sub-word stores.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_wr,
  input  logic [1:0]            i_size0,
  input  logic [1:0]            i_size1,
  input  logic [WORD_WIDTH-1:0] i_addr0,
  input  logic [WORD_WIDTH-1:0] i_addr1,
  input  logic [WORD_WIDTH-1:0] i_wdata0,
  input  logic [WORD_WIDTH-1:0] i_wdata1,
  output logic [1:0]            o_ack,
  output logic                  o_err,
  output logic [WORD_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_mem_wr,
  output logic [WORD_WIDTH-1:0] o_mem_addr,
  output logic [WORD_WIDTH-1:0] o_mem_wdata,
  input  logic [WORD_WIDTH-1:0] i_mem_rdata
);

  state_e                r_state, w_next;
  logic                  r_id, r_wr, r_err;
  logic [1:0]            r_size;
  logic [WORD_WIDTH-1:0] r_addr, r_wdata, r_rdata, r_merge;

  logic [1:0]            w_gnt;
  logic                  w_grant, w_sel, w_wr, w_bad;
  logic [1:0]            w_size;
  logic [WORD_WIDTH-1:0] w_addr, w_wdata, w_extract, w_merge;
  logic                  w_word_store, w_sub_store;

  rr_arb2 u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_grant_en   (r_state == ST_IDLE),
    .i_fixed_prio (FIXED_PRIO),
    .o_gnt        (w_gnt)
  );

  assign w_grant      = |w_gnt;
  assign w_sel        = w_gnt[1];
  assign w_wr         = i_wr[w_sel];
  assign w_size       = w_sel ? i_size1  : i_size0;
  assign w_addr       = w_sel ? i_addr1  : i_addr0;
  assign w_wdata      = w_sel ? i_wdata1 : i_wdata0;
  assign w_bad        = access_err(w_size, w_addr[1:0]);
  assign w_word_store = r_wr && (r_size == SZ_WORD);
  assign w_sub_store  = r_wr && (r_size != SZ_WORD);

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    w_extract = i_mem_rdata;
    w_merge   = i_mem_rdata;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0: begin
            w_extract      = {24'd0, i_mem_rdata[31:24]};
            w_merge[31:24] = r_wdata[7:0];
          end
          2'd1: begin
            w_extract      = {24'd0, i_mem_rdata[23:16]};
            w_merge[23:16] = r_wdata[7:0];
          end
          2'd2: begin
            w_extract      = {24'd0, i_mem_rdata[15:8]};
            w_merge[15:8]  = r_wdata[7:0];
          end
          default: begin
            w_extract      = {24'd0, i_mem_rdata[7:0]};
            w_merge[7:0]   = r_wdata[7:0];
          end
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) begin
          w_extract      = {16'd0, i_mem_rdata[15:0]};
          w_merge[15:0]  = r_wdata[15:0];
        end else begin
          w_extract      = {16'd0, i_mem_rdata[31:16]};
          w_merge[31:16] = r_wdata[15:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_next = w_bad ? ST_DONE : ST_ACCESS;
      ST_ACCESS: w_next = w_sub_store ? ST_WRITE : ST_DONE;
      ST_WRITE:  w_next = ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Write strobe is gated by reset so an abandoned access never reaches memory.
  always_comb begin
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if ((r_state == ST_ACCESS) || (r_state == ST_WRITE)) begin
      o_mem_addr = {r_addr[31:2], 2'b00};
    end
    if ((r_state == ST_ACCESS) && w_word_store) begin
      o_mem_wr    = !i_rst;
      o_mem_wdata = r_wdata;
    end
    if (r_state == ST_WRITE) begin
      o_mem_wr    = !i_rst;
      o_mem_wdata = r_merge;
    end
  end

  assign o_ack   = (r_state == ST_DONE) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign o_err   = (r_state == ST_DONE) && r_err;
  assign o_rdata = r_rdata;
  assign o_busy  = (r_state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_id    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_merge <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_id    <= w_sel;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_bad;
            if (w_bad) r_rdata <= '0;
          end
        end
        ST_ACCESS: begin
          r_rdata <= r_wr ? '0 : w_extract;
          r_merge <= w_merge;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - randomized scoreboard bench for datamem_arbiter
`timescale 1ns/1ps
module tb_datamem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wexp_t;

  localparam logic [31:0] FKEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wr, size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic        err, busy, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [1:0]  f_req, f_wr, f_size0, f_size1, f_ack;
  logic [31:0] f_addr0, f_addr1, f_wdata0, f_wdata1;
  logic        f_err, f_busy, f_mem_wr;
  logic [31:0] f_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;

  logic [31:0] dmem [0:63];
  logic [7:0]  ref_mem [0:255];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  exp_t  expq[$];
  wexp_t wq[$];
  txn_t  pend0[$];
  txn_t  pend1[$];

  bit in_flight;
  int ack_at, next_idle, cur_port, ref_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata   = dmem[mem_addr[7:2]];
  assign f_mem_rdata = f_mem_addr ^ FKEY;
  always @(posedge clk) if (mem_wr) dmem[mem_addr[7:2]] <= mem_wdata;

  datamem_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr),
    .i_size0(size0), .i_size1(size1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_busy(busy),
    .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  datamem_arbiter #(.FIXED_PRIO(1'b1)) u_fix (
    .i_clk(clk), .i_rst(rst), .i_req(f_req), .i_wr(f_wr),
    .i_size0(f_size0), .i_size1(f_size1), .i_addr0(f_addr0), .i_addr1(f_addr1),
    .i_wdata0(f_wdata0), .i_wdata1(f_wdata1),
    .o_ack(f_ack), .o_err(f_err), .o_rdata(f_rdata), .o_busy(f_busy),
    .o_mem_wr(f_mem_wr), .o_mem_addr(f_mem_addr), .o_mem_wdata(f_mem_wdata),
    .i_mem_rdata(f_mem_rdata)
  );

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
  endfunction

  // Reference behaviour straight from the access rules on a byte array.
  task automatic ref_apply(input txn_t t, output logic e, output logic [31:0] rd, output int lat);
    int n;
    logic [31:0] a;
    a  = t.addr;
    e  = (t.size == 2'b11) || (t.size == 2'b01 && a[0]) || (t.size == 2'b10 && a[1:0] != 2'b00);
    rd = 32'd0;
    if (e) begin
      lat = 1;
      return;
    end
    n = 1 << t.size;
    if (!t.wr) begin
      for (int i = 0; i < n; i++) rd = (rd << 8) | {24'd0, ref_mem[8'(a + 32'(i))]};
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = 8'(t.wdata >> (8 * (n - 1 - i)));
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    logic [7:0] a;
    t.wr   = 1'($urandom_range(0, 1));
    t.size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    a      = 8'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (t.size == 2'b01) a[0] = 1'b0;
      else if (t.size == 2'b10) a[1:0] = 2'b00;
    end
    t.addr  = {24'd0, a};
    t.wdata = $urandom;
    return t;
  endfunction

  function automatic txn_t mk(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = w; t.size = s; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic present(input int p, input txn_t t);
    req[p] = 1'b1;
    wr[p]  = t.wr;
    if (p == 0) begin
      size0 = t.size; addr0 = t.addr; wdata0 = t.wdata;
    end else begin
      size1 = t.size; addr1 = t.addr; wdata1 = t.wdata;
    end
  endtask

  // Model timeline: predicts which IDLE cycle samples which port and when it completes.
  task automatic step_model();
    txn_t t;
    logic e;
    logic [31:0] rd, wa;
    int lat, g;
    exp_t x;
    wexp_t w;
    if (in_flight && cyc == ack_at) begin
      in_flight = 1'b0;
      if (cur_port == 0) begin
        void'(pend0.pop_front());
        if (pend0.size() != 0) present(0, pend0[0]); else req[0] = 1'b0;
      end else begin
        void'(pend1.pop_front());
        if (pend1.size() != 0) present(1, pend1[0]); else req[1] = 1'b0;
      end
    end
    if (!in_flight && cyc >= next_idle && req != 2'b00) begin
      if (req == 2'b11) g = (ref_last == 1) ? 0 : 1;
      else g = req[1] ? 1 : 0;
      ref_last = g;
      t = (g == 1) ? pend1[0] : pend0[0];
      ref_apply(t, e, rd, lat);
      x.port = 1'(g); x.err = e; x.rdata = rd; x.cyc = 32'(cyc + lat);
      expq.push_back(x);
      if (t.wr && !e) begin
        wa = {t.addr[31:2], 2'b00};
        w.addr = wa; w.data = ref_word(wa); w.cyc = 32'(cyc + lat - 1);
        wq.push_back(w);
      end
      in_flight = 1'b1;
      cur_port  = g;
      ack_at    = cyc + lat;
      next_idle = ack_at + 1;
    end
  endtask

  task automatic run_step(input int d1);
    int t;
    t = 0;
    if (pend0.size() != 0) present(0, pend0[0]);
    while ((pend0.size() != 0 || pend1.size() != 0 || in_flight) && t < 200) begin
      if (t == d1 && pend1.size() != 0 && !req[1]) present(1, pend1[0]);
      step_model();
      if (pend0.size() != 0 || pend1.size() != 0 || in_flight) begin
        tick();
        t++;
      end
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL step_timeout: got %0d cycles expected under 200", t);
    end
  endtask

  task automatic wait_idle();
    while (cyc < next_idle) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_ack"}, {30'd0, ack}, 32'd0);
    chk_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    chk_eq({tag, "_rdata"}, rdata, 32'd0);
    chk_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk_eq({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic reset_mid_store();
    int c0;
    wait_idle();
    present(0, mk(1'b1, 2'b00, 32'h21, 32'h77));
    c0 = cyc;
    while (cyc < c0 + 2) tick();
    rst = 1'b1;
    #1;
    chk_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    req = 2'b00;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    ref_last  = 1;
    in_flight = 1'b0;
    next_idle = cyc;
  endtask

  task automatic fixed_prio_test();
    logic [3:0] order;
    int n0, nacks;
    f_wr = 2'b00; f_size0 = 2'b10; f_size1 = 2'b10;
    f_addr0 = 32'h40; f_addr1 = 32'h80;
    f_req = 2'b11;
    n0 = 0; nacks = 0; order = 4'd0;
    for (int t = 0; t < 40 && nacks < 4; t++) begin
      tick();
      if (f_ack != 2'b00) begin
        chk_eq("fix_rdata", f_rdata, (f_ack[1] ? f_addr1 : f_addr0) ^ FKEY);
        chk_eq("fix_err", {31'd0, f_err}, 32'd0);
        order[nacks] = f_ack[1];
        nacks++;
        if (f_ack[0]) begin
          n0++;
          if (n0 < 3) f_addr0 = f_addr0 + 32'd4; else f_req[0] = 1'b0;
        end
        if (f_ack[1]) f_req[1] = 1'b0;
      end
    end
    chk_eq("fix_nacks", 32'(nacks), 32'd4);
    chk_eq("fix_order", {28'd0, order}, 32'h8);
  endtask

  always @(negedge clk) begin
    exp_t x;
    wexp_t w;
    if (ack != 2'b00) begin
      if (expq.size() == 0) begin
        chk_eq("ack_unexpected", {30'd0, ack}, 32'd0);
      end else begin
        x = expq.pop_front();
        chk_eq("ack_port", {30'd0, ack}, x.port ? 32'd2 : 32'd1);
        chk_eq("ack_err", {31'd0, err}, {31'd0, x.err});
        chk_eq("ack_rdata", rdata, x.rdata);
        chk_eq("ack_cycle", 32'(cyc), x.cyc);
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        chk_eq("mem_wr_unexpected", {31'd0, mem_wr}, 32'd0);
      end else begin
        w = wq.pop_front();
        chk_eq("wr_addr", mem_addr, w.addr);
        chk_eq("wr_data", mem_wdata, w.data);
        chk_eq("wr_cycle", 32'(cyc), w.cyc);
      end
    end
  end

  initial begin
    logic [31:0] v;
    int n0, n1;
    rst = 1'b1; req = 2'b00; wr = 2'b00; size0 = 2'b00; size1 = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    f_req = 2'b00; f_wr = 2'b00; f_size0 = 2'b00; f_size1 = 2'b00;
    f_addr0 = '0; f_addr1 = '0; f_wdata0 = '0; f_wdata1 = '0;
    in_flight = 1'b0; next_idle = 0; ref_last = 1; cur_port = 0; ack_at = 0;
    for (int w = 0; w < 64; w++) begin
      v = $urandom;
      if (w == 4) v = 32'h0;
      if (w == 8) v = 32'h1122_3344;
      dmem[w] <= v;
      for (int b = 0; b < 4; b++) ref_mem[w * 4 + b] = 8'(v >> (24 - 8 * b));
    end
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    next_idle = cyc;

    pend0.push_back(mk(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF));
    pend0.push_back(mk(1'b0, 2'b10, 32'h10, 32'h0));
    run_step(0);
    tick();
    pend1.push_back(mk(1'b1, 2'b00, 32'h22, 32'hFFFF_FFAA));
    pend1.push_back(mk(1'b0, 2'b01, 32'h20, 32'h0));
    run_step(0);
    tick();
    pend0.push_back(mk(1'b0, 2'b01, 32'h31, 32'h0));
    pend0.push_back(mk(1'b0, 2'b11, 32'h30, 32'h0));
    run_step(0);
    tick();
    for (int k = 0; k < 3; k++) begin
      pend0.push_back(mk(1'b0, 2'b10, 32'h00, 32'h0));
      pend1.push_back(mk(1'b0, 2'b10, 32'h04, 32'h0));
      run_step(0);
      tick();
    end

    for (int s = 0; s < 150; s++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) pend0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) pend1.push_back(rand_txn());
      run_step($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    reset_mid_store();
    for (int s = 0; s < 10; s++) begin
      pend0.push_back(rand_txn());
      pend1.push_back(rand_txn());
      run_step(0);
      tick();
    end
    wait_idle();
    repeat (3) tick();

    fixed_prio_test();
    repeat (2) tick();

    for (int w = 0; w < 64; w++) chk_eq($sformatf("mem_%0d", w), dmem[w], ref_word(32'(w * 4)));
    chk_eq("pending_acks", 32'(expq.size()), 32'd0);
    chk_eq("pending_writes", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Sequences and shares the byte-addressed, big-endian data memory between two requesters: port 0 is the pipeline MEM stage and port 1 is a debug/DMA master. It arbitrates with a round-robin grant and performs word, halfword and byte accesses. Sub-word stores are done as read-modify-write, because the memory has only a full-word write port. It sits between the requesters and the data memory, and owns the memory's `data_wr`, `data_addr` and `data_in`.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes port 0 always win.

Ports:
- `clk` in 1: single clock; memory writes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req[1:0]` in 2: request per port; held stable until that port's `ack`.
- `wr[1:0]` in 2: 1 means store, 0 means load.
- `size0`, `size1` in 2 each: 00 byte, 01 half, 10 word, 11 reserved.
- `addr0`, `addr1` in 32 each: byte address.
- `wdata0`, `wdata1` in 32 each: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ack[1:0]` out 2: one-cycle completion pulse per port.
- `err` out 1: valid with `ack`; set for misaligned access or reserved size.
- `rdata` out 32: load result, zero-extended and right-aligned; valid with `ack`.
- `busy` out 1: high when the state machine is not in IDLE.
- `mem_wr` out 1: to the memory's `data_wr`.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: memory read word; combinational read of `mem_addr`.

## Operation
- **Byte order:** big-endian. Byte at offset k of the word lies in bits [31-8k:24-8k]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- **States:** IDLE, ACCESS, WRITE, DONE.
- **IDLE:**
  - If any `req` is high, choose the winner and latch id, wr, size, addr and wdata. Go to ACCESS.
  - If the latched access is misaligned (half with addr[0]=1, or word with addr[1:0]≠0) or size=11, go directly to DONE with `err`=1. No memory access occurs.
- **Arbitration:**
  - A single requester wins.
  - When both request: with `FIXED_PRIO`=0, the port not granted last wins; with `FIXED_PRIO`=1, port 0 wins.
  - `last_grant` updates on each grant and resets to 1, so port 0 wins the first tie.
- **ACCESS:** `mem_addr` = {addr[31:2], 2'b00}.
  - Load: extract the sub-word from `mem_rdata` and register it into `rdata`. Go to DONE.
  - Word store: `mem_wr`=1, `mem_wdata`=wdata. Go to DONE.
  - Byte or half store: register `mem_rdata` merged with the new lane(s) into the merge register. Go to WRITE.
- **WRITE:** `mem_wr`=1, `mem_wdata`=merge register, same `mem_addr`. Go to DONE.
- **DONE:** `ack[id]`=1 for exactly one cycle, with `err` and `rdata` valid. Go to IDLE.
- **Requester rule:**
  - The requester drops or changes `req` in the cycle after `ack`.
  - A `req` still high in IDLE is treated as a new request.
  - Requests arriving while `busy` wait; they are neither dropped nor queued beyond the level `req`.
- **rdata hold:** `rdata` holds its last value between loads. It is 0 after a store or an error ack.

## Timing
- Reset values: state IDLE, `ack`=0, `err`=0, `rdata`=0, `busy`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `last_grant`=1.
- `mem_wr` is combinational from the state and is forced to 0 while `rst`=1. A reset during ACCESS or WRITE therefore never writes memory, and the in-flight access is abandoned with no `ack`.
- Latency, counted from the cycle `req` is sampled in IDLE (cycle 0):
  - Load, word store: `ack` in cycle 2.
  - Byte or half store: `ack` in cycle 3.
  - Error: `ack` in cycle 1.
- Throughput: one access per 3 cycles (4 for sub-word stores), because IDLE is always visited between accesses.
- Memory write takes effect at the posedge ending ACCESS (word store) or ending WRITE (sub-word store). A load issued later sees the new data.

## Structure
- Shared package `datamem_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state encoding;
  - `WORD_WIDTH`=32.
- One sub-module, `rr_arb2`: the two-input round-robin arbiter, with inputs `req[1:0]`, `grant_en` and `fixed_prio`; outputs one-hot `gnt[1:0]`; holds the `last_grant` register.
- Extract and merge lane logic stays in `datamem_arbiter`.

## Test plan
- **Word store then load:** memory preloaded to 0. Port 0 stores word 0xDEADBEEF to 0x10, then loads 0x10 → `ack0` in cycle 2 each time; `rdata`=0xDEADBEEF; bytes 0x10..0x13 = DE AD BE EF.
- **Byte RMW:** word 0x20 = 0x11223344. Port 1 stores byte 0xAA to 0x22 → `mem_wr` high only in WRITE with `mem_wdata`=0x1122AA44; `ack1` in cycle 3. A following half load of 0x20 returns 0x00001122.
- **Simultaneous requests:** `req`=11 on three consecutive grants → grants go 0, 1, 0. With `FIXED_PRIO`=1 → 0, 0, 0 while port 0 holds `req`.
- **Misaligned and reserved:** half load at 0x31 → `ack` in cycle 1, `err`=1, `rdata`=0, no `mem_wr`. Size 11 gives the same result.
- **Reset mid-store:** `rst` asserted during the WRITE of a byte store → memory unchanged, no `ack`, all outputs at their reset values the next cycle.
- **Back-to-back same port:** port 0 keeps `req` high across `ack` with a new addr → second access starts from IDLE; no duplicate `ack` for the first access.
